// File: rtl/line_buffer_scheduler_pkg.sv
// Shared types and helpers for the line buffer scheduler: FSM state encoding
// and the index-width helper that stands in for the legacy LOG2 macro.
package line_buffer_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Never narrower than one bit, so sizes of 1 or 2 still yield a legal vector.
    function automatic int idxWidth(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/line_buffer_scheduler_if.sv
// Pixel-in / window-out handshake bundle between the stream source, the
// scheduler and the MAC array.
interface line_buffer_scheduler_if #(
    parameter int IMAGE_SIZE = 28
);
    import line_buffer_scheduler_pkg::*;

    localparam int W = idxWidth(IMAGE_SIZE);

    logic         in_valid;
    logic         in_ready;
    logic         lb_clk_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] win_x;
    logic [W-1:0] win_y;

    modport slave (
        input  in_valid, out_ready,
        output in_ready, lb_clk_en, out_valid, win_x, win_y
    );

    modport master (
        output in_valid, out_ready,
        input  in_ready, lb_clk_en, out_valid, win_x, win_y
    );

endinterface

// File: rtl/line_buffer_scheduler_axis_stride_counter.sv
// One raster axis: position, stride phase and the output-map index of the
// next window, all advanced by counting so no divider is needed.
module axis_stride_counter
    import line_buffer_scheduler_pkg::*;
#(
    parameter int FILTER_SIZE = 3,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 1,
    parameter int W           = idxWidth(IMAGE_SIZE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_step,
    output logic [W-1:0] o_pos,
    output logic         o_at_last,
    output logic         o_in_window,
    output logic [W-1:0] o_out_idx
);

    localparam int PW = idxWidth(STRIDE);
    localparam logic [W-1:0]  POS_LAST      = W'(IMAGE_SIZE - 1);
    localparam logic [W-1:0]  POS_FIRST_WIN = W'(FILTER_SIZE - 1);
    localparam logic [PW-1:0] PHASE_LAST    = PW'(STRIDE - 1);

    logic [W-1:0]  r_pos;
    logic [W-1:0]  r_out_idx;
    logic [PW-1:0] r_phase;

    assign o_pos       = r_pos;
    assign o_out_idx   = r_out_idx;
    assign o_at_last   = (r_pos == POS_LAST);
    assign o_in_window = (r_pos >= POS_FIRST_WIN) && (r_phase == '0);

    // Phase is pinned to 0 until the kernel fits, then cycles 0..STRIDE-1;
    // the output index advances once per window position crossed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos     <= '0;
            r_phase   <= '0;
            r_out_idx <= '0;
        end else if (i_clear) begin
            r_pos     <= '0;
            r_phase   <= '0;
            r_out_idx <= '0;
        end else if (i_step) begin
            if (o_at_last) begin
                r_pos     <= '0;
                r_phase   <= '0;
                r_out_idx <= '0;
            end else begin
                r_pos <= r_pos + 1'b1;
                if ((r_pos < POS_FIRST_WIN) || (r_phase == PHASE_LAST)) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
                if (o_in_window) begin
                    r_out_idx <= r_out_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/line_buffer_scheduler.sv
// Frame sequencer for the conv line buffer: accepts pixels, drives the line
// buffer enable and issues one held window handshake per output position.
module line_buffer_scheduler
    import line_buffer_scheduler_pkg::*;
#(
    parameter int FILTER_SIZE = 3,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    line_buffer_scheduler_if.slave   bus
);

    localparam int W = idxWidth(IMAGE_SIZE);

    state_t       r_state;
    state_t       w_next_state;
    logic         r_out_valid;
    logic [W-1:0] r_win_x;
    logic [W-1:0] r_win_y;

    logic         w_start_frame;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_window;
    logic         w_last_pixel;
    logic         w_x_at_last, w_y_at_last;
    logic         w_x_in_window, w_y_in_window;
    logic [W-1:0] w_x_pos, w_y_pos;
    logic [W-1:0] w_x_out_idx, w_y_out_idx;
    logic         w_unused;

    // Input is held off while a window waits for the MAC array, so the line
    // buffer never overwrites rows a pending window still needs.
    assign w_start_frame = (r_state == ST_IDLE) && i_start;
    assign w_in_ready    = (r_state == ST_STREAM) && !(r_out_valid && !bus.out_ready);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_window      = w_accept && w_x_in_window && w_y_in_window;
    assign w_last_pixel  = w_accept && w_x_at_last && w_y_at_last;
    assign w_unused      = ^{w_x_pos, w_y_pos};

    assign bus.in_ready  = w_in_ready;
    assign bus.lb_clk_en = w_accept;
    assign bus.out_valid = r_out_valid;
    assign bus.win_x     = r_win_x;
    assign bus.win_y     = r_win_y;

    axis_stride_counter #(
        .FILTER_SIZE(FILTER_SIZE), .IMAGE_SIZE(IMAGE_SIZE), .STRIDE(STRIDE), .W(W)
    ) u_x_axis (
        .clk(clk), .rst(rst), .i_clear(w_start_frame), .i_step(w_accept),
        .o_pos(w_x_pos), .o_at_last(w_x_at_last),
        .o_in_window(w_x_in_window), .o_out_idx(w_x_out_idx)
    );

    axis_stride_counter #(
        .FILTER_SIZE(FILTER_SIZE), .IMAGE_SIZE(IMAGE_SIZE), .STRIDE(STRIDE), .W(W)
    ) u_y_axis (
        .clk(clk), .rst(rst), .i_clear(w_start_frame), .i_step(w_accept && w_x_at_last),
        .o_pos(w_y_pos), .o_at_last(w_y_at_last),
        .o_in_window(w_y_in_window), .o_out_idx(w_y_out_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                o_busy = 1'b1;
                if (w_last_pixel) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (!r_out_valid || bus.out_ready) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A freshly completed window wins over the retiring handshake so that
    // back-to-back windows stream at full rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_win_x     <= '0;
            r_win_y     <= '0;
        end else if (w_start_frame) begin
            r_out_valid <= 1'b0;
            r_win_x     <= '0;
            r_win_y     <= '0;
        end else if (w_window) begin
            r_out_valid <= 1'b1;
            r_win_x     <= w_x_out_idx;
            r_win_y     <= w_y_out_idx;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_win_x     <= '0;
            r_win_y     <= '0;
        end
    end

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Directed bench for line_buffer_scheduler: three configurations
// (5x5 stride 1, 5x5 stride 2, 6x6 stride 2) with a 3x3 kernel.
module tb_line_buffer_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] monClear = '0;
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;

    line_buffer_scheduler_if #(.IMAGE_SIZE(5)) bus0 ();
    line_buffer_scheduler_if #(.IMAGE_SIZE(5)) bus1 ();
    line_buffer_scheduler_if #(.IMAGE_SIZE(6)) bus2 ();

    line_buffer_scheduler #(.FILTER_SIZE(3), .IMAGE_SIZE(5), .STRIDE(1)) dut0 (
        .clk(clk), .rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]), .bus(bus0)
    );
    line_buffer_scheduler #(.FILTER_SIZE(3), .IMAGE_SIZE(5), .STRIDE(2)) dut1 (
        .clk(clk), .rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]), .bus(bus1)
    );
    line_buffer_scheduler #(.FILTER_SIZE(3), .IMAGE_SIZE(6), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .i_start(start[2]), .o_busy(busy[2]), .o_done(done[2]), .bus(bus2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    logic [2:0] lbEn, outValid, outReady, inValid;
    logic [2:0] winX [3];
    logic [2:0] winY [3];
    assign lbEn     = {bus2.lb_clk_en, bus1.lb_clk_en, bus0.lb_clk_en};
    assign outValid = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign outReady = {bus2.out_ready, bus1.out_ready, bus0.out_ready};
    assign inValid  = {bus2.in_valid,  bus1.in_valid,  bus0.in_valid};
    assign winX[0] = bus0.win_x;  assign winY[0] = bus0.win_y;
    assign winX[1] = bus1.win_x;  assign winY[1] = bus1.win_y;
    assign winX[2] = bus2.win_x;  assign winY[2] = bus2.win_y;

    // Observation record per instance: accepts, window handshakes (with the
    // accept count at which each window was issued) and done pulses.
    int accCnt[3], lastAccCyc[3], acc13Cyc[3], firstValidCyc[3];
    int doneCnt[3], doneCyc[3], lastHsCyc[3], nWin[3], spurious[3];
    int wxA[3][10], wyA[3][10], waA[3][10];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (monClear[i]) begin
                accCnt[i] = 0; lastAccCyc[i] = 0; acc13Cyc[i] = 0; firstValidCyc[i] = -1;
                doneCnt[i] = 0; doneCyc[i] = 0; lastHsCyc[i] = 0; nWin[i] = 0; spurious[i] = 0;
            end else begin
                if (outValid[i] && firstValidCyc[i] < 0) firstValidCyc[i] = cycle;
                if (outValid[i] && outReady[i]) begin
                    if (nWin[i] < 10) begin
                        wxA[i][nWin[i]] = int'(winX[i]);
                        wyA[i][nWin[i]] = int'(winY[i]);
                        waA[i][nWin[i]] = accCnt[i];
                    end
                    nWin[i]      = nWin[i] + 1;
                    lastHsCyc[i] = cycle;
                end
                if (lbEn[i]) begin
                    accCnt[i]     = accCnt[i] + 1;
                    lastAccCyc[i] = cycle;
                    if (accCnt[i] == 13) acc13Cyc[i] = cycle;
                end
                if (lbEn[i] && !inValid[i]) spurious[i] = spurious[i] + 1;
                if (done[i]) begin
                    doneCnt[i] = doneCnt[i] + 1;
                    doneCyc[i] = cycle;
                end
            end
        end
    end

    task automatic startFrame(input logic [2:0] mask);
        @(posedge clk); #1;
        start    = mask;
        monClear = mask;
        @(posedge clk); #1;
        start    = '0;
        monClear = '0;
    endtask

    task automatic waitDone(input int idx, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done[idx]) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b0;
        #2;
        checks++;
        if ({bus0.in_ready, bus0.lb_clk_en, bus0.out_valid, busy[0], done[0]} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {bus0.in_ready, bus0.lb_clk_en, bus0.out_valid, busy[0], done[0]});
        end
        checks++;
        if ({bus0.win_x, bus0.win_y} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_win: got (%0d,%0d) expected (0,0)", bus0.win_x, bus0.win_y);
        end
        @(negedge clk);
        rst = 1'b0;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus0.lb_clk_en, bus0.in_ready, busy[0]} !== 3'b0) begin
                failures++;
                $display("[TB] FAIL idle_ignores_valid: got %b expected 000",
                         {bus0.lb_clk_en, bus0.in_ready, busy[0]});
            end
        end
        bus0.in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        bit seen;
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        startFrame(3'b001);
        waitDone(0, 200, seen);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        checks++;
        if (seen !== 1'b1) begin failures++; $display("[TB] FAIL nominal_done_timeout: got 0 expected 1"); end
        checks++;
        if (nWin[0] !== 9) begin failures++; $display("[TB] FAIL nominal_count: got %0d expected 9", nWin[0]); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (wxA[0][k] !== k % 3 || wyA[0][k] !== k / 3 || waA[0][k] !== (k / 3 + 2) * 5 + k % 3 + 3) begin
                failures++;
                $display("[TB] FAIL nominal_win%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", k,
                         wxA[0][k], wyA[0][k], waA[0][k], k % 3, k / 3, (k / 3 + 2) * 5 + k % 3 + 3);
            end
        end
        checks++;
        if (firstValidCyc[0] - acc13Cyc[0] !== 1) begin
            failures++;
            $display("[TB] FAIL first_window_latency: got %0d expected 1", firstValidCyc[0] - acc13Cyc[0]);
        end
        checks++;
        if (doneCyc[0] - lastHsCyc[0] !== 1 || doneCyc[0] - lastAccCyc[0] !== 2) begin
            failures++;
            $display("[TB] FAIL nominal_done_timing: got hs+%0d acc+%0d expected hs+1 acc+2",
                     doneCyc[0] - lastHsCyc[0], doneCyc[0] - lastAccCyc[0]);
        end
        checks++;
        if (accCnt[0] !== 25 || doneCnt[0] !== 1 || busy[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nominal_totals: got acc=%0d done=%0d busy=%0d expected 25 1 0",
                     accCnt[0], doneCnt[0], busy[0]);
        end
    endtask

    task automatic test_stride();
        bit seen1, seen2;
        int ex[4] = '{0, 1, 0, 1};
        int ey[4] = '{0, 0, 1, 1};
        int ea1[4] = '{13, 15, 23, 25};
        int ea2[4] = '{15, 17, 27, 29};
        bus1.in_valid = 1'b1;
        bus2.in_valid = 1'b1;
        startFrame(3'b110);
        waitDone(1, 200, seen1);
        waitDone(2, 200, seen2);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        checks++;
        if (seen1 !== 1'b1 || seen2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stride_done_timeout: got %0d%0d expected 11", seen1, seen2);
        end
        checks++;
        if (nWin[1] !== 4 || nWin[2] !== 4) begin
            failures++;
            $display("[TB] FAIL stride_count: got %0d/%0d expected 4/4", nWin[1], nWin[2]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wxA[1][k] !== ex[k] || wyA[1][k] !== ey[k] || waA[1][k] !== ea1[k]) begin
                failures++;
                $display("[TB] FAIL s2_i5_win%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", k,
                         wxA[1][k], wyA[1][k], waA[1][k], ex[k], ey[k], ea1[k]);
            end
            checks++;
            if (wxA[2][k] !== ex[k] || wyA[2][k] !== ey[k] || waA[2][k] !== ea2[k]) begin
                failures++;
                $display("[TB] FAIL s2_i6_win%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", k,
                         wxA[2][k], wyA[2][k], waA[2][k], ex[k], ey[k], ea2[k]);
            end
        end
        checks++;
        if (doneCyc[2] - lastAccCyc[2] !== 2 || accCnt[2] !== 36 || doneCnt[2] !== 1) begin
            failures++;
            $display("[TB] FAIL s2_i6_done: got acc+%0d acc=%0d done=%0d expected acc+2 36 1",
                     doneCyc[2] - lastAccCyc[2], accCnt[2], doneCnt[2]);
        end
        checks++;
        if (doneCyc[1] - lastAccCyc[1] !== 2 || doneCnt[1] !== 1) begin
            failures++;
            $display("[TB] FAIL s2_i5_done: got acc+%0d done=%0d expected acc+2 1",
                     doneCyc[1] - lastAccCyc[1], doneCnt[1]);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        startFrame(3'b001);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus0.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_valid_timeout: got 0 expected 1"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus0.in_ready, bus0.lb_clk_en, bus0.out_valid, bus0.win_x, bus0.win_y} !== 9'b001_000_000) begin
                failures++;
                $display("[TB] FAIL bp_stall%0d: got rdy=%0d en=%0d vld=%0d win=(%0d,%0d) expected 0 0 1 (0,0)", i,
                         bus0.in_ready, bus0.lb_clk_en, bus0.out_valid, bus0.win_x, bus0.win_y);
            end
            @(negedge clk);
        end
        checks++;
        if (accCnt[0] !== 13) begin failures++; $display("[TB] FAIL bp_accepts_held: got %0d expected 13", accCnt[0]); end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        waitDone(0, 200, seen);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        checks++;
        if (seen !== 1'b1 || nWin[0] !== 9 || doneCnt[0] !== 1) begin
            failures++;
            $display("[TB] FAIL bp_totals: got done_seen=%0d wins=%0d dones=%0d expected 1 9 1", seen, nWin[0], doneCnt[0]);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (wxA[0][k] !== k % 3 || wyA[0][k] !== k / 3) begin
                failures++;
                $display("[TB] FAIL bp_win%0d: got (%0d,%0d) expected (%0d,%0d)", k, wxA[0][k], wyA[0][k], k % 3, k / 3);
            end
        end
    endtask

    task automatic test_gapped();
        bit seen;
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        startFrame(3'b001);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            bus0.in_valid = ~bus0.in_valid;
            @(negedge clk);
            if (done[0]) seen = 1'b1;
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        checks++;
        if (seen !== 1'b1 || nWin[0] !== 9 || accCnt[0] !== 25 || spurious[0] !== 0) begin
            failures++;
            $display("[TB] FAIL gapped_totals: got done_seen=%0d wins=%0d acc=%0d spurious=%0d expected 1 9 25 0",
                     seen, nWin[0], accCnt[0], spurious[0]);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (wxA[0][k] !== k % 3 || wyA[0][k] !== k / 3 || waA[0][k] !== (k / 3 + 2) * 5 + k % 3 + 3) begin
                failures++;
                $display("[TB] FAIL gapped_win%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", k,
                         wxA[0][k], wyA[0][k], waA[0][k], k % 3, k / 3, (k / 3 + 2) * 5 + k % 3 + 3);
            end
        end
    endtask

    task automatic test_abort();
        bit seen;
        int cnt;
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        startFrame(3'b001);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 10; c++) begin
            @(negedge clk);
            if (bus0.lb_clk_en) cnt++;
        end
        checks++;
        if (cnt !== 10) begin failures++; $display("[TB] FAIL abort_reach10: got %0d expected 10", cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus0.in_ready, bus0.lb_clk_en, bus0.out_valid, busy[0], done[0], bus0.win_x, bus0.win_y} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got rdy=%0d en=%0d vld=%0d busy=%0d done=%0d win=(%0d,%0d) expected all 0",
                     bus0.in_ready, bus0.lb_clk_en, bus0.out_valid, busy[0], done[0], bus0.win_x, bus0.win_y);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (doneCnt[0] !== 0 || busy[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: got dones=%0d busy=%0d expected 0 0", doneCnt[0], busy[0]);
        end
        bus0.in_valid = 1'b1;
        startFrame(3'b001);
        waitDone(0, 200, seen);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        checks++;
        if (seen !== 1'b1 || nWin[0] !== 9 || doneCnt[0] !== 1) begin
            failures++;
            $display("[TB] FAIL abort_restart: got done_seen=%0d wins=%0d dones=%0d expected 1 9 1", seen, nWin[0], doneCnt[0]);
        end
        checks++;
        if (wxA[0][8] !== 2 || wyA[0][8] !== 2 || wxA[0][0] !== 0 || wyA[0][0] !== 0) begin
            failures++;
            $display("[TB] FAIL abort_restart_wins: got first (%0d,%0d) last (%0d,%0d) expected (0,0) (2,2)",
                     wxA[0][0], wyA[0][0], wxA[0][8], wyA[0][8]);
        end
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        $display("[TB] line_buffer_scheduler bench starting");
        test_reset();
        test_nominal();
        test_stride();
        test_backpressure();
        test_gapped();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
